// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 bridge: line refills and single reads on the read
// channels, whole-line writebacks from a line buffer on the write channels.
// Read and write run independent FSMs with a same-line read-after-write hold.
//
// read state | meaning
// R_IDLE     | rd_rdy high, waiting for a cache read
// R_AR       | presenting AR (held off while a same-line write is in flight)
// R_DATA     | accepting R beats into ret_data
// R_RET      | one-cycle ret_valid pulse
//
// write state | meaning
// W_IDLE      | wr_rdy high, waiting for a writeback pulse
// W_BURST     | AW and W in flight, each finishing independently
// W_RESP      | waiting for the B response
module dcache_axi_bridge #(
  parameter int          ID_W  = 4,
  parameter int unsigned RD_ID = 0,
  parameter int unsigned WR_ID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_req,
  input  logic [2:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic [255:0]    ret_data,
  input  logic            wr_req,
  input  logic [31:0]     wr_addr,
  input  logic [3:0]      wr_wstrb,
  input  logic [255:0]    wr_data,
  output logic            wr_rdy,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} wr_state_e;

  rd_state_e    rd_state_q, rd_state_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic [2:0]   arsize_q, arsize_d;
  logic [1:0]   arburst_q, arburst_d;
  logic         ar_sent_q, ar_sent_d;
  logic [2:0]   beat_cnt_q, beat_cnt_d;
  logic [255:0] ret_data_q, ret_data_d;

  wr_state_e    wr_state_q, wr_state_d;
  logic [26:0]  wline_q, wline_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [255:0] wbuf_q, wbuf_d;
  logic [2:0]   wbeat_q, wbeat_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic [7:0]   awlen_q, awlen_d;
  logic [2:0]   awsize_q, awsize_d;
  logic [1:0]   awburst_q, awburst_d;

  logic rd_blocked;
  logic unused_inputs;

  assign unused_inputs = ^{rid, rresp, bid, bresp, wr_addr[4:0]};

  // Once AR has been shown it stays up until accepted, even if a
  // same-line write starts afterwards.
  assign rd_blocked = (wr_state_q != W_IDLE) && (araddr_q[31:5] == wline_q) && !ar_sent_q;

  assign rd_rdy    = (rd_state_q == R_IDLE);
  assign ret_valid = (rd_state_q == R_RET);
  assign ret_data  = ret_data_q;
  assign arid      = ID_W'(RD_ID);
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = arburst_q;
  assign arvalid   = (rd_state_q == R_AR) && !rd_blocked;
  assign rready    = (rd_state_q == R_DATA);

  assign wr_rdy  = (wr_state_q == W_IDLE);
  assign awid    = ID_W'(WR_ID);
  assign awaddr  = {wline_q, 5'b0};
  assign awlen   = awlen_q;
  assign awsize  = awsize_q;
  assign awburst = awburst_q;
  assign awvalid = (wr_state_q == W_BURST) && !aw_done_q;
  assign wvalid  = (wr_state_q == W_BURST) && !w_done_q;
  assign wdata   = wbuf_q[{wbeat_q, 5'b0} +: 32];
  assign wstrb   = wstrb_q;
  assign wlast   = (wbeat_q == 3'd7);
  assign bready  = (wr_state_q == W_RESP);

  // Read FSM next state, AR payload capture and beat packing.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    ar_sent_d  = 1'b0;
    beat_cnt_d = beat_cnt_q;
    ret_data_d = ret_data_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_req) begin
          rd_state_d = R_AR;
          arburst_d  = 2'b01;
          if (rd_type[2]) begin
            araddr_d = {rd_addr[31:5], 5'b0};
            arlen_d  = 8'd7;
            arsize_d = 3'd2;
          end else begin
            araddr_d = rd_addr;
            arlen_d  = 8'd0;
            arsize_d = {1'b0, rd_type[1:0]};
          end
        end
      end
      R_AR: begin
        if (arvalid) begin
          if (arready) begin
            rd_state_d = R_DATA;
            beat_cnt_d = 3'd0;
          end else begin
            ar_sent_d = 1'b1;
          end
        end
      end
      R_DATA: begin
        if (rvalid) begin
          // First beat also clears the rest so single reads return zeros above.
          if (beat_cnt_q == 3'd0) ret_data_d = {224'b0, rdata};
          else                    ret_data_d[{beat_cnt_q, 5'b0} +: 32] = rdata;
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (rlast) rd_state_d = R_RET;
        end
      end
      R_RET:   rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      ar_sent_q  <= 1'b0;
      beat_cnt_q <= '0;
      ret_data_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      ar_sent_q  <= ar_sent_d;
      beat_cnt_q <= beat_cnt_d;
      ret_data_q <= ret_data_d;
    end
  end

  // Write FSM next state: line capture, independent AW/W completion.
  always_comb begin
    wr_state_d = wr_state_q;
    wline_d    = wline_q;
    wstrb_d    = wstrb_q;
    wbuf_d     = wbuf_q;
    wbeat_d    = wbeat_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awlen_d    = awlen_q;
    awsize_d   = awsize_q;
    awburst_d  = awburst_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wr_state_d = W_BURST;
          wline_d    = wr_addr[31:5];
          wstrb_d    = wr_wstrb;
          wbuf_d     = wr_data;
          wbeat_d    = 3'd0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awlen_d    = 8'd7;
          awsize_d   = 3'd2;
          awburst_d  = 2'b01;
        end
      end
      W_BURST: begin
        if (!aw_done_q && awready) aw_done_d = 1'b1;
        if (!w_done_q && wready) begin
          wbeat_d = wbeat_q + 3'd1;
          if (wbeat_q == 3'd7) w_done_d = 1'b1;
        end
        if ((aw_done_q || awready) && (w_done_q || (wready && wbeat_q == 3'd7)))
          wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write state register and line buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wline_q    <= '0;
      wstrb_q    <= '0;
      wbuf_q     <= '0;
      wbeat_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wline_q    <= wline_d;
      wstrb_q    <= wstrb_d;
      wbuf_q     <= wbuf_d;
      wbeat_q    <= wbeat_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
    end
  end

endmodule
